// File: rtl/psc_trigger_rx_pkg.sv
// PSC trigger link receiver: shared constants,
// line codes and FSM state encoding.
package psc_trigger_pkg;

  localparam int FRAME_BITS  = 10;
  localparam int LOCK_COUNT  = 4;
  localparam int UNLOCK_ERRS = 3;

  localparam logic [9:0] IDLE_WORD = 10'b0011111010;
  localparam logic [9:0] TRIG_WORD = 10'b1100000101;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'b00,
    ST_CHECK  = 2'b01,
    ST_LOCKED = 2'b10
  } state_e;

  function automatic logic is_code(input logic [9:0] w);
    return (w == IDLE_WORD) || (w == TRIG_WORD);
  endfunction

endpackage

// File: rtl/psc_trigger_rx_if.sv
// PSC trigger link receiver: line input,
// error-clear strobe and status outputs.
interface psc_trigger_rx_if;

  logic        rx_bit;
  logic        err_clr;
  logic        locked;
  logic        trigger_out;
  logic        code_err;
  logic [15:0] err_count;

  modport master (
    output rx_bit, err_clr,
    input  locked, trigger_out,
    input  code_err, err_count
  );

  modport slave (
    input  rx_bit, err_clr,
    output locked, trigger_out,
    output code_err, err_count
  );

endinterface

// File: rtl/psc_word_aligner.sv
// PSC trigger link receiver: line shift register
// and word phase counter with realign reload.
module psc_word_aligner
  import psc_trigger_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_bit,
  input  logic       i_align,
  output logic [9:0] o_shreg,
  output logic       o_word_complete
);

  logic [9:0] r_shreg;
  logic [3:0] r_phase;
  logic       w_wrap;

  assign w_wrap = (r_phase == 4'(FRAME_BITS - 1));

  // Shift the line in every cycle; phase wraps 9->0
  // or restarts at 1 when the current window is a word.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_shreg <= '0;
      r_phase <= '0;
    end else begin
      r_shreg <= {r_shreg[8:0], i_bit};
      if (i_align)
        r_phase <= 4'd1;
      else if (w_wrap)
        r_phase <= '0;
      else
        r_phase <= r_phase + 4'd1;
    end
  end

  assign o_shreg         = r_shreg;
  assign o_word_complete = (r_phase == 4'd0);

endmodule

// File: rtl/psc_trigger_rx.sv
// PSC trigger link receiver top: lock FSM,
// good/bad word counters and registered outputs.
module psc_trigger_rx
  import psc_trigger_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  psc_trigger_rx_if.slave  bus
);

  state_e      r_state, w_state_nxt;
  logic [2:0]  r_good, w_good_nxt;
  logic [1:0]  r_bad, w_bad_nxt;
  logic        r_locked, w_locked_nxt;
  logic        r_trig, w_trig_nxt;
  logic        r_cerr, w_cerr_nxt;
  logic [15:0] r_err_count, w_err_nxt;
  logic        w_align;
  logic        w_err_inc;
  logic [9:0]  w_shreg;
  logic        w_wc;
  logic        w_valid;

  psc_word_aligner u_align (
    .i_clk           (clk),
    .i_reset         (reset),
    .i_bit           (bus.rx_bit),
    .i_align         (w_align),
    .o_shreg         (w_shreg),
    .o_word_complete (w_wc)
  );

  assign w_valid = is_code(w_shreg);

  // Register FSM state, counters and all outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_HUNT;
      r_good      <= '0;
      r_bad       <= '0;
      r_locked    <= 1'b0;
      r_trig      <= 1'b0;
      r_cerr      <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_good      <= w_good_nxt;
      r_bad       <= w_bad_nxt;
      r_locked    <= w_locked_nxt;
      r_trig      <= w_trig_nxt;
      r_cerr      <= w_cerr_nxt;
      r_err_count <= w_err_nxt;
    end
  end

  // Hunt every cycle; check and track words only
  // at word boundaries once aligned.
  always_comb begin
    w_state_nxt  = r_state;
    w_good_nxt   = r_good;
    w_bad_nxt    = r_bad;
    w_locked_nxt = r_locked;
    w_trig_nxt   = 1'b0;
    w_cerr_nxt   = 1'b0;
    w_align      = 1'b0;
    w_err_inc    = 1'b0;
    case (r_state)
      ST_HUNT: begin
        w_good_nxt = '0;
        if (w_valid) begin
          w_align     = 1'b1;
          w_good_nxt  = 3'd1;
          w_state_nxt = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (w_wc) begin
          if (w_valid) begin
            w_good_nxt = r_good + 3'd1;
            if (r_good + 3'd1 == 3'(LOCK_COUNT)) begin
              w_state_nxt  = ST_LOCKED;
              w_locked_nxt = 1'b1;
              w_bad_nxt    = '0;
            end
          end else begin
            w_good_nxt  = '0;
            w_state_nxt = ST_HUNT;
          end
        end
      end
      ST_LOCKED: begin
        if (w_wc) begin
          unique case (1'b1)
            (w_shreg == TRIG_WORD): begin
              w_trig_nxt = 1'b1;
              w_bad_nxt  = '0;
            end
            (w_shreg == IDLE_WORD): begin
              w_bad_nxt = '0;
            end
            default: begin
              w_cerr_nxt = 1'b1;
              w_err_inc  = 1'b1;
              w_bad_nxt  = r_bad + 2'd1;
              if (r_bad + 2'd1 == 2'(UNLOCK_ERRS)) begin
                w_state_nxt  = ST_HUNT;
                w_locked_nxt = 1'b0;
                w_good_nxt   = '0;
                w_bad_nxt    = '0;
              end
            end
          endcase
        end
      end
      default: begin
        w_state_nxt  = ST_HUNT;
        w_good_nxt   = '0;
        w_bad_nxt    = '0;
        w_locked_nxt = 1'b0;
      end
    endcase
  end

  // Saturating error count; a clear beats a coincident error.
  always_comb begin
    w_err_nxt = r_err_count;
    if (bus.err_clr)
      w_err_nxt = '0;
    else if (w_err_inc && (r_err_count != 16'hFFFF))
      w_err_nxt = r_err_count + 16'd1;
  end

  assign bus.locked      = r_locked;
  assign bus.trigger_out = r_trig;
  assign bus.code_err    = r_cerr;
  assign bus.err_count   = r_err_count;

endmodule

// File: tb/tb_psc_trigger_rx.sv
// Randomised bench for psc_trigger_rx with a
// word-level reference model of the link receiver.
module tb_psc_trigger_rx;

  localparam logic [9:0] IDLE = 10'b0011111010;
  localparam logic [9:0] TRIG = 10'b1100000101;
  localparam logic [9:0] BADW = 10'h155;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;
  int   n_trig;
  int   n_cerr;

  psc_trigger_rx_if bus ();

  psc_trigger_rx dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: recent line bits, bits into current word,
  // link mode (0 searching, 1 confirming, 2 locked)
  int          m_win;
  int          m_pos;
  int          m_mode;
  int          m_good;
  int          m_bad;
  logic        m_locked;
  logic        m_trig;
  logic        m_cerr;
  logic [15:0] m_err;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic model(input logic b, input logic c,
                       input logic r);
    bit is_valid;
    bit at_word;
    int npos;
    if (r) begin
      m_win = 0; m_pos = 0; m_mode = 0;
      m_good = 0; m_bad = 0;
      m_locked = 0; m_trig = 0; m_cerr = 0;
      m_err = 0;
      return;
    end
    is_valid = (m_win == int'(IDLE)) ||
               (m_win == int'(TRIG));
    at_word = (m_pos == 0);
    npos = (m_pos + 1) % 10;
    m_trig = 0;
    m_cerr = 0;
    if (m_mode == 0) begin
      if (is_valid) begin
        npos = 1; m_good = 1; m_mode = 1;
      end
    end else if (m_mode == 1) begin
      if (at_word) begin
        if (is_valid) begin
          m_good++;
          if (m_good == 4) begin
            m_mode = 2; m_locked = 1; m_bad = 0;
          end
        end else begin
          m_mode = 0; m_good = 0;
        end
      end
    end else if (at_word) begin
      if (m_win == int'(TRIG)) begin
        m_trig = 1; m_bad = 0;
      end else if (m_win == int'(IDLE)) begin
        m_bad = 0;
      end else begin
        m_cerr = 1;
        if (m_err != 16'hFFFF) m_err = m_err + 1;
        m_bad++;
        if (m_bad == 3) begin
          m_mode = 0; m_locked = 0; m_good = 0;
        end
      end
    end
    if (c) m_err = 0;
    m_win = ((m_win << 1) | int'(b)) & 32'h3FF;
    m_pos = npos;
  endtask

  task automatic step(input logic b, input logic c,
                      input logic r);
    bus.rx_bit  = b;
    bus.err_clr = c;
    reset       = r;
    @(posedge clk);
    model(b, c, r);
    #1;
    chk("locked", 32'(bus.locked), 32'(m_locked));
    chk("trigger_out", 32'(bus.trigger_out), 32'(m_trig));
    chk("code_err", 32'(bus.code_err), 32'(m_cerr));
    chk("err_count", 32'(bus.err_count), 32'(m_err));
    if (bus.trigger_out) n_trig++;
    if (bus.code_err) n_cerr++;
  endtask

  task automatic send_word(input logic [9:0] w);
    for (int i = 9; i >= 0; i--) step(w[i], 1'b0, 1'b0);
  endtask

  task automatic send_rand(input int n);
    for (int i = 0; i < n; i++)
      step(1'($urandom_range(0, 1)), 1'b0, 1'b0);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    logic [9:0] w;
    n_tests = 0; n_fail = 0;
    n_trig = 0; n_cerr = 0;
    bus.rx_bit = 1'b0;
    bus.err_clr = 1'b0;
    reset = 1'b1;

    // 1: reset then IDLE stream at bit offset 3
    do_reset(3);
    chk("rst_locked", 32'(bus.locked), 32'd0);
    chk("rst_err_count", 32'(bus.err_count), 32'd0);
    send_rand(3);
    for (int k = 0; k < 6; k++) send_word(IDLE);
    chk("s1_locked", 32'(bus.locked), 32'd1);
    chk("s1_no_trig", 32'(n_trig), 32'd0);

    // 2: single TRIG, then three back-to-back
    n_trig = 0;
    send_word(TRIG);
    send_word(IDLE);
    send_word(IDLE);
    for (int k = 0; k < 3; k++) send_word(TRIG);
    send_word(IDLE);
    chk("s2_trig_count", 32'(n_trig), 32'd4);

    // 3: one corrupt word, then three in a row
    send_word(BADW);
    send_word(IDLE);
    chk("s3_err1", 32'(bus.err_count), 32'd1);
    chk("s3_still_locked", 32'(bus.locked), 32'd1);
    for (int k = 0; k < 3; k++) send_word(BADW);
    step(IDLE[9], 1'b0, 1'b0);
    chk("s3_err4", 32'(bus.err_count), 32'd4);
    chk("s3_unlocked", 32'(bus.locked), 32'd0);
    w = IDLE;
    for (int i = 8; i >= 0; i--) step(w[i], 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) send_word(IDLE);

    // 4: TRIG inside lock-acquisition window
    do_reset(2);
    n_trig = 0;
    send_word(IDLE);
    send_word(TRIG);
    send_word(IDLE);
    send_word(IDLE);
    send_word(IDLE);
    chk("s4_locked", 32'(bus.locked), 32'd1);
    chk("s4_no_trig", 32'(n_trig), 32'd0);

    // 5: saturation, then clear coinciding with an error
    @(negedge clk);
    dut.r_err_count = 16'hFFFF;
    m_err = 16'hFFFF;
    send_word(BADW);
    w = IDLE;
    step(w[9], 1'b0, 1'b0);
    chk("s5_sat", 32'(bus.err_count), 32'hFFFF);
    for (int i = 8; i >= 0; i--) step(w[i], 1'b0, 1'b0);
    send_word(BADW);
    step(w[9], 1'b1, 1'b0);
    chk("s5_clr_cnt", 32'(bus.err_count), 32'd0);
    chk("s5_clr_pulse", 32'(bus.code_err), 32'd1);
    for (int i = 8; i >= 0; i--) step(w[i], 1'b0, 1'b0);

    // 6: reset mid-word while locked, then relock
    for (int i = 9; i >= 5; i--) step(w[i], 1'b0, 1'b0);
    do_reset(1);
    chk("s6_locked", 32'(bus.locked), 32'd0);
    chk("s6_trig", 32'(bus.trigger_out), 32'd0);
    chk("s6_cerr", 32'(bus.code_err), 32'd0);
    chk("s6_err", 32'(bus.err_count), 32'd0);
    send_rand(3);
    for (int k = 0; k < 6; k++) send_word(IDLE);
    chk("s6_relock", 32'(bus.locked), 32'd1);

    // random traffic: codes, corrupt words, bit slips, clears
    for (int k = 0; k < 400; k++) begin
      int sel;
      sel = $urandom_range(0, 19);
      if (sel < 12) w = IDLE;
      else if (sel < 16) w = TRIG;
      else if (sel < 19) w = 10'($urandom_range(0, 1023));
      else begin
        send_rand($urandom_range(1, 3));
        w = IDLE;
      end
      for (int i = 9; i >= 0; i--)
        step(w[i], 1'($urandom_range(0, 49) == 0), 1'b0);
      if ($urandom_range(0, 99) == 0) do_reset(1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
